// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the alu_core execution stage.
//   WIDTH_DEFAULT : default operand/result width.
//   alu_op_e      : 4-bit opcode encoding (ADD .. NAND, values 0-15).
// -----------------------------------------------------------------------------
package alu_pkg;

   localparam int WIDTH_DEFAULT = 5;

   typedef enum logic [3:0] {
      OP_ADD  = 4'd0,
      OP_SUB  = 4'd1,
      OP_INC  = 4'd2,
      OP_DEC  = 4'd3,
      OP_AND  = 4'd4,
      OP_OR   = 4'd5,
      OP_XOR  = 4'd6,
      OP_NOT  = 4'd7,
      OP_SHL  = 4'd8,
      OP_SHR  = 4'd9,
      OP_ROL  = 4'd10,
      OP_ROR  = 4'd11,
      OP_ASR  = 4'd12,
      OP_SLT  = 4'd13,
      OP_EQ   = 4'd14,
      OP_NAND = 4'd15
   } alu_op_e;

endpackage

// File: rtl/alu_shifter.sv
// -----------------------------------------------------------------------------
// alu_shifter
// Combinational shift/rotate unit for opcodes SHL, SHR, ROL, ROR and ASR.
// Ports:
//   A    (in,  WIDTH) : operand to shift
//   k    (in,  3)     : shift/rotate amount
//   op   (in,  4)     : opcode; non-shift opcodes yield zero
//   res  (out, WIDTH) : shifted/rotated result
//   sout (out, 1)     : last bit shifted out (0 for rotates and k = 0)
// -----------------------------------------------------------------------------
module alu_shifter
   import alu_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT
) (
   input  logic [WIDTH-1:0] A,
   input  logic [2:0]       k,
   input  alu_op_e          op,
   output logic [WIDTH-1:0] res,
   output logic             sout
);

   localparam int unsigned W_U = WIDTH;

   // One guard bit beyond the operand catches the last bit shifted out.
   // Amounts past WIDTH push everything (guard included) off the end, which
   // gives the required zero result and zero shift-out for free.
   logic               [WIDTH:0]   shl_ext;
   logic               [WIDTH:0]   shr_ext;
   logic signed        [WIDTH:0]   asr_ext;
   int unsigned                    rot_amt;
   logic               [WIDTH-1:0] rol_res;
   logic               [WIDTH-1:0] ror_res;

   always_comb begin
      shl_ext = {1'b0, A} << k;
      shr_ext = {A, 1'b0} >> k;
      // Sign fill keeps the guard bit equal to the sign once k >= WIDTH.
      asr_ext = $signed({A, 1'b0}) >>> k;

      rot_amt = 32'(k) % W_U;
      // With rot_amt = 0 the complementary shift is by WIDTH, i.e. zero.
      rol_res = (A << rot_amt) | (A >> (W_U - rot_amt));
      ror_res = (A >> rot_amt) | (A << (W_U - rot_amt));

      res  = '0;
      sout = 1'b0;
      case (op)
         OP_SHL: begin
            res  = shl_ext[WIDTH-1:0];
            sout = shl_ext[WIDTH];
         end
         OP_SHR: begin
            res  = shr_ext[WIDTH:1];
            sout = shr_ext[0];
         end
         OP_ROL: res = rol_res;
         OP_ROR: res = ror_res;
         OP_ASR: begin
            res  = asr_ext[WIDTH:1];
            sout = asr_ext[0];
         end
         default: begin
            res  = '0;
            sout = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/alu_core.sv
// -----------------------------------------------------------------------------
// alu_core
// Registered WIDTH-bit ALU: arithmetic, bitwise, shift/rotate and compare,
// selected by a 4-bit opcode, with results presented one clock later.
// Optional feature macro: ALU_ZERO_FLAG_EN adds the registered Zero output.
// Ports:
//   clk   (in,  1)     : rising-edge clock
//   rst_n (in,  1)     : asynchronous active-low reset
//   S     (in,  4)     : opcode (alu_pkg::alu_op_e)
//   A     (in,  WIDTH) : operand A
//   B     (in,  WIDTH) : operand B (B[2:0] is the shift amount)
//   Y     (out, WIDTH) : registered result
//   Cout  (out, 1)     : registered carry/borrow/shift-out flag
//   Zero  (out, 1)     : registered Y == 0 (only with ALU_ZERO_FLAG_EN)
// -----------------------------------------------------------------------------
module alu_core
   import alu_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [3:0]       S,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic [WIDTH-1:0] Y,
   output logic             Cout
`ifdef ALU_ZERO_FLAG_EN
   ,
   output logic             Zero
`endif
);

   alu_op_e                   op;
   logic        [WIDTH:0]     sum_ext;
   logic        [WIDTH:0]     diff_ext;
   logic        [WIDTH:0]     inc_ext;
   logic signed [WIDTH-1:0]   a_s;
   logic signed [WIDTH-1:0]   b_s;
   logic        [WIDTH-1:0]   sh_res;
   logic                      sh_out;
   logic        [WIDTH-1:0]   y_d;
   logic                      cout_d;
   logic        [WIDTH-1:0]   y_q;
   logic                      cout_q;

   assign op  = alu_op_e'(S);
   assign a_s = A;
   assign b_s = B;

   alu_shifter #(
      .WIDTH (WIDTH)
   ) u_shifter (
      .A    (A),
      .k    (B[2:0]),
      .op   (op),
      .res  (sh_res),
      .sout (sh_out)
   );

   always_comb begin
      // Extra MSB carries the carry (ADD/INC) or the borrow (SUB).
      sum_ext  = {1'b0, A} + {1'b0, B};
      diff_ext = {1'b0, A} - {1'b0, B};
      inc_ext  = {1'b0, A} + {{WIDTH{1'b0}}, 1'b1};

      y_d    = '0;
      cout_d = 1'b0;
      case (op)
         OP_ADD: begin
            y_d    = sum_ext[WIDTH-1:0];
            cout_d = sum_ext[WIDTH];
         end
         OP_SUB: begin
            y_d    = diff_ext[WIDTH-1:0];
            cout_d = diff_ext[WIDTH];
         end
         OP_INC: begin
            y_d    = inc_ext[WIDTH-1:0];
            cout_d = inc_ext[WIDTH];
         end
         OP_DEC: begin
            y_d    = A - {{(WIDTH-1){1'b0}}, 1'b1};
            cout_d = (A == '0);
         end
         OP_AND:  y_d = A & B;
         OP_OR:   y_d = A | B;
         OP_XOR:  y_d = A ^ B;
         OP_NOT:  y_d = ~A;
         OP_SHL, OP_SHR, OP_ROL, OP_ROR, OP_ASR: begin
            y_d    = sh_res;
            cout_d = sh_out;
         end
         OP_SLT:  y_d = {{(WIDTH-1){1'b0}}, (a_s < b_s)};
         OP_EQ:   y_d = {{(WIDTH-1){1'b0}}, (A == B)};
         OP_NAND: y_d = ~(A & B);
         default: begin
            y_d    = '0;
            cout_d = 1'b0;
         end
      endcase
   end

   // Output register stage
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         y_q    <= '0;
         cout_q <= 1'b0;
      end else begin
         y_q    <= y_d;
         cout_q <= cout_d;
      end
   end

   assign Y    = y_q;
   assign Cout = cout_q;

`ifdef ALU_ZERO_FLAG_EN
   logic zero_q;

   // Zero is computed from the next result so it lines up with Y.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         zero_q <= 1'b1;
      end else begin
         zero_q <= (y_d == '0);
      end
   end

   assign Zero = zero_q;
`endif

endmodule

// File: tb/tb_alu_core.sv
module tb_alu_core;

   localparam int W = 5;

   typedef struct packed {
      logic [W-1:0] y;
      logic         c;
   } res_t;

   typedef struct packed {
      logic [3:0]   s;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] y;
      logic         c;
   } vec_t;

   logic         clk;
   logic         rst_n;
   logic [3:0]   S;
   logic [W-1:0] A;
   logic [W-1:0] B;
   logic [W-1:0] Y;
   logic         Cout;
`ifdef ALU_ZERO_FLAG_EN
   logic         Zero;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   logic [W-1:0] exp_y;
   logic         exp_c;
   logic         exp_vld = 1'b0;

   alu_core #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .S     (S),
      .A     (A),
      .B     (B),
      .Y     (Y),
      .Cout  (Cout)
`ifdef ALU_ZERO_FLAG_EN
      ,
      .Zero  (Zero)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: plain integer arithmetic straight from the opcode rules.
   function automatic res_t model(input logic [3:0] s, input logic [W-1:0] av, input logic [W-1:0] bv);
      int a, b, k, r, sa, sb, y, c, m;
      res_t o;
      m  = 1 << W;
      a  = int'(av);
      b  = int'(bv);
      k  = int'(bv[2:0]);
      sa = (a >= m / 2) ? a - m : a;
      sb = (b >= m / 2) ? b - m : b;
      r  = k % W;
      y  = 0;
      c  = 0;
      case (s)
         4'd0:  begin y = (a + b) % m; c = (a + b >= m) ? 1 : 0; end
         4'd1:  begin y = (a - b + m) % m; c = (a < b) ? 1 : 0; end
         4'd2:  begin y = (a + 1) % m; c = (a + 1 >= m) ? 1 : 0; end
         4'd3:  begin y = (a + m - 1) % m; c = (a == 0) ? 1 : 0; end
         4'd4:  y = a & b;
         4'd5:  y = a | b;
         4'd6:  y = a ^ b;
         4'd7:  y = (m - 1) - a;
         4'd8:  begin
            if (k == 0) y = a;
            else if (k <= W) begin y = (a * (1 << k)) % m; c = (a >> (W - k)) & 1; end
         end
         4'd9:  begin
            if (k == 0) y = a;
            else if (k <= W) begin y = a / (1 << k); c = (a >> (k - 1)) & 1; end
         end
         4'd10: y = ((a * (1 << r)) + (a >> (W - r))) % m;
         4'd11: y = ((a >> r) + (a * (1 << (W - r)))) % m;
         4'd12: begin
            if (k == 0) y = a;
            else begin
               y = (sa >>> k) & (m - 1);
               c = (k <= W) ? ((a >> (k - 1)) & 1) : ((a >> (W - 1)) & 1);
            end
         end
         4'd13: y = (sa < sb) ? 1 : 0;
         4'd14: y = (a == b) ? 1 : 0;
         default: y = (m - 1) - (a & b);
      endcase
      o.y = y[W-1:0];
      o.c = c[0];
      return o;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: actual %0d required %0d", name, act, req);
      end
   endtask

   // Expected outputs track the DUT's one-cycle latency and reset.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         exp_y   <= '0;
         exp_c   <= 1'b0;
         exp_vld <= 1'b1;
      end else begin
         exp_y <= model(S, A, B).y;
         exp_c <= model(S, A, B).c;
      end
   end

   // Single compare process, away from the active edge.
   always @(negedge clk) begin
      if (exp_vld) begin
         check("cyc_Y", 32'(Y), 32'(exp_y));
         check("cyc_Cout", 32'(Cout), 32'(exp_c));
`ifdef ALU_ZERO_FLAG_EN
         check("cyc_Zero", 32'(Zero), 32'(exp_y == '0));
`endif
      end
   end

   vec_t dir[15];

   initial begin
      res_t r;
      dir[0]  = '{4'd0,  5'd26, 5'd17, 5'd11, 1'b1};
      dir[1]  = '{4'd1,  5'd26, 5'd17, 5'd9,  1'b0};
      dir[2]  = '{4'd2,  5'd26, 5'd17, 5'd27, 1'b0};
      dir[3]  = '{4'd3,  5'd26, 5'd17, 5'd25, 1'b0};
      dir[4]  = '{4'd4,  5'd26, 5'd17, 5'd16, 1'b0};
      dir[5]  = '{4'd5,  5'd26, 5'd17, 5'd27, 1'b0};
      dir[6]  = '{4'd6,  5'd26, 5'd17, 5'd11, 1'b0};
      dir[7]  = '{4'd7,  5'd26, 5'd17, 5'd5,  1'b0};
      dir[8]  = '{4'd8,  5'd11, 5'd1,  5'd22, 1'b0};
      dir[9]  = '{4'd9,  5'd11, 5'd1,  5'd5,  1'b1};
      dir[10] = '{4'd10, 5'd11, 5'd1,  5'd22, 1'b0};
      dir[11] = '{4'd11, 5'd11, 5'd1,  5'd21, 1'b0};
      dir[12] = '{4'd12, 5'd11, 5'd1,  5'd5,  1'b1};
      dir[13] = '{4'd13, 5'd3,  5'd17, 5'd0,  1'b0};
      dir[14] = '{4'd13, 5'd2,  5'd11, 5'd1,  1'b0};

      // Asynchronous reset with random inputs, before any capturing edge.
      rst_n = 1'b1;
      S = 4'($urandom); A = 5'($urandom); B = 5'($urandom);
      #1 rst_n = 1'b0;
      #1;
      check("rst_Y", 32'(Y), 0);
      check("rst_Cout", 32'(Cout), 0);
`ifdef ALU_ZERO_FLAG_EN
      check("rst_Zero", 32'(Zero), 1);
`endif
      S = 4'($urandom); A = 5'($urandom); B = 5'($urandom);
      @(negedge clk); #1;
      check("rst_hold_Y", 32'(Y), 0);
      rst_n = 1'b1;

      // Pin the reference model to hand-computed values.
      for (int i = 0; i < 15; i++) begin
         r = model(dir[i].s, dir[i].a, dir[i].b);
         check($sformatf("lit_Y_%0d", i), 32'(r.y), 32'(dir[i].y));
         check($sformatf("lit_C_%0d", i), 32'(r.c), 32'(dir[i].c));
      end
      r = model(4'd8, 5'd10, 5'd1);  check("lit_shl10", 32'({r.y, r.c}), 32'({5'd20, 1'b0}));
      r = model(4'd14, 5'd11, 5'd11); check("lit_eq", 32'({r.y, r.c}), 32'({5'd1, 1'b0}));
      r = model(4'd15, 5'd31, 5'd31); check("lit_nand", 32'({r.y, r.c}), 32'({5'd0, 1'b0}));
      r = model(4'd3, 5'd0, 5'd0);   check("lit_dec0", 32'({r.y, r.c}), 32'({5'd31, 1'b1}));
      r = model(4'd12, 5'd16, 5'd5); check("lit_asr", 32'({r.y, r.c}), 32'({5'd31, 1'b1}));

      // Directed vectors through the DUT, checked against literals too.
      for (int i = 0; i < 15; i++) begin
         @(negedge clk); #1;
         S = dir[i].s; A = dir[i].a; B = dir[i].b;
         @(posedge clk); #1;
         check($sformatf("dut_Y_%0d", i), 32'(Y), 32'(dir[i].y));
         check($sformatf("dut_C_%0d", i), 32'(Cout), 32'(dir[i].c));
      end

      // Reset between two back-to-back operations.
      @(negedge clk); #1;
      S = 4'd0; A = 5'd26; B = 5'd17;
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_Y", 32'(Y), 0);
      check("mid_rst_C", 32'(Cout), 0);
      @(negedge clk); #1;
      S = 4'd2; A = 5'd5; B = 5'd0;
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("post_rst_Y", 32'(Y), 6);

      // Randomized operation with occasional reset pulses.
      for (int i = 0; i < 600; i++) begin
         @(negedge clk); #1;
         rst_n = ($urandom_range(0, 49) == 0) ? 1'b0 : 1'b1;
         S = 4'($urandom);
         A = 5'($urandom);
         B = 5'($urandom);
      end
      @(negedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk); #1;
      @(negedge clk); #1;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/alu_core.md
# alu_core

Registered 5-bit arithmetic/logic unit selected by a 4-bit opcode. Computes arithmetic, bitwise, shift/rotate and compare results from operands `A` and `B`, then presents result `Y` and carry/flag `Cout` one clock later. Sits in the datapath as the single execution stage between operand sourcing and writeback.

## Interface
Parameters:
- `WIDTH`, default 5. Operand and result width. Verified at 5 only.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `S`  in  4  opcode.
- `A`  in  WIDTH  operand A.
- `B`  in  WIDTH  operand B.
- `Y`  out  WIDTH  registered result.
- `Cout`  out  1  registered carry/borrow/shift-out flag.
- `Zero`  out  1  registered `Y == 0`; present only under `ALU_ZERO_FLAG_EN`.

## Operation
All arithmetic is unsigned modulo 2^WIDTH unless marked signed. `Cout` is 0 wherever no rule is given.

Opcodes (`S`):
- 0 ADD: `Y = A+B`; `Cout` = carry out.
- 1 SUB: `Y = A-B`; `Cout` = borrow (1 when A < B unsigned).
- 2 INC: `Y = A+1`; `Cout` = carry.
- 3 DEC: `Y = A-1`; `Cout` = borrow (1 when A = 0).
- 4 AND: `A & B`.
- 5 OR: `A | B`.
- 6 XOR: `A ^ B`.
- 7 NOT: `~A`.

Shift and rotate (amount k = `B[2:0]`):
- 8 SHL: `A << k`; `Cout` = last bit shifted out (A[WIDTH-k] for 1 ≤ k ≤ WIDTH).
- 9 SHR logical: `A >> k`; `Cout` = A[k-1] for 1 ≤ k ≤ WIDTH.
- 10 ROL and 11 ROR: rotate by k mod WIDTH; `Cout` = 0.
- 12 ASR: arithmetic right shift, sign-filled; `Cout` = A[k-1] for 1 ≤ k ≤ WIDTH, else A[WIDTH-1].
- Boundaries: k = 0 gives `Y = A`, `Cout = 0`. For SHL/SHR, k > WIDTH gives `Y = 0`, `Cout = 0`. For ASR, k ≥ WIDTH gives `Y` all sign bits.

Compare and remaining logic:
- 13 SLT: `Y = {0…, (signed A < signed B)}`.
- 14 EQ: `Y = {0…, A == B}`.
- 15 NAND: `~(A & B)`.

## Timing
- Result computation is combinational. `Y`, `Cout` and `Zero` are registered on the rising edge of `clk`.
- Latency is exactly 1 cycle. Throughput is one operation per cycle, with no handshake.
- Asserting `rst_n` low immediately (asynchronously) drives `Y = 0`, `Cout = 0` and `Zero = 1`.
- After release, the first capture is at the next rising edge.
- Reset asserted mid-stream discards the in-flight result.

## Configuration
- `ALU_ZERO_FLAG_EN` defined: the `Zero` port and its register exist. `Zero` is registered alongside `Y`.
- `ALU_ZERO_FLAG_EN` undefined: there is no `Zero` port and no register for it. All other behaviour is identical.

## Structure
- Package `alu_pkg` holds:
  - `WIDTH_DEFAULT = 5`.
  - The opcode enum `alu_op_e` (ADD … NAND, values 0–15).
- Sub-module `alu_shifter` holds the combinational shifts and rotates for opcodes 8–12.
  - Inputs: `A`, `k`, op.
  - Outputs: result and shift-out.
- The top level holds the opcode mux plus the output registers.

## Test plan
- Reset: hold `rst_n` = 0 with random inputs -> `Y` = 0, `Cout` = 0 (`Zero` = 1), with no clock needed.
- A=26, B=17 across S=0..7, checked one cycle after each apply:
  - S=0 -> Y=11, Cout=1. S=1 -> Y=9, Cout=0. S=2 -> Y=27, Cout=0. S=3 -> Y=25, Cout=0.
  - S=4 -> Y=16. S=5 -> Y=27. S=6 -> Y=11. S=7 -> Y=5.
- A=11, B=1 with S=8..12:
  - S=8 -> Y=22, Cout=0. S=9 -> Y=5, Cout=1. S=10 -> Y=22. S=11 -> Y=21. S=12 -> Y=5, Cout=1.
  - A=10, B=1, S=8 -> Y=20, Cout=0.
- Signed compare:
  - A=3, B=17, S=13 -> Y=0 (17 is −15 signed).
  - A=2, B=11, S=13 -> Y=1.
- Equality and NAND:
  - A=B=11, S=14 -> Y=1.
  - A=B=31, S=15 -> Y=0 (`Zero`=1 when enabled).
- Boundaries and reset:
  - A=0, S=3 -> Y=31, Cout=1.
  - A=16, B=5, S=12 -> Y=31.
  - Assert `rst_n` between two back-to-back ops -> output goes to 0 immediately, and the second op appears one cycle after release.
